// File: rtl/io_sim_mem.sv
// Bus-slave memory model for the DLX dual-core bus with programmable wait states,
// abort handling, out-of-range error responses, access counters and a run/step front end.
module io_sim_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int AO_WIDTH   = 32,
  parameter int DEF_WAIT   = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  AS_N,
  input  logic                  WR_N,
  input  logic [AO_WIDTH-1:0]   AO,
  input  logic [DATA_WIDTH-1:0] DO,
  output logic                  ACK_N,
  output logic [DATA_WIDTH-1:0] DI,
  input  logic [3:0]            ws_cfg,
  input  logic                  ws_load,
  input  logic                  run_mode,
  input  logic                  step_in,
  output logic                  step_en,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [1:0]            dbg_state
);

  // Handshake: the master holds AS_N low with AO/WR_N/DO stable; the slave answers with
  // a single-cycle ACK_N low and waits for AS_N high before accepting the next strobe.
  // Raising AS_N before the ACK aborts the transfer with no side effects.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2, RELEASE = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic [AO_WIDTH-1:0]     addr_q, addr_d;
  logic                    wrn_q, wrn_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              ws_q, ws_d;
  logic                    ack_n_q, ack_n_d;
  logic [DATA_WIDTH-1:0]   di_q, di_d;
  logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;
  logic                    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic                    step_en_q, step_en_d;
  logic                    mem_we;
  logic                    in_range;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_range = ((addr_q >> ADDR_WIDTH) == '0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wrn_d     = wrn_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    ack_n_d   = 1'b1;
    di_d      = di_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!AS_N) begin
          addr_d  = AO;
          wrn_d   = WR_N;
          data_d  = DO;
          cnt_d   = ws_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (AS_N) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          ack_n_d = 1'b0;
          if (in_range) begin
            if (!wrn_q) begin
              mem_we   = 1'b1;
              wr_cnt_d = sat_inc(wr_cnt_q);
            end else begin
              di_d     = mem[addr_q[ADDR_WIDTH-1:0]];
              rd_cnt_d = sat_inc(rd_cnt_q);
            end
          end else begin
            err_cnt_d = sat_inc(err_cnt_q);
            if (wrn_q) di_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = RELEASE;
      RELEASE: if (AS_N) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ws_d      = ws_load ? ws_cfg : ws_q;
    s1_d      = step_in;
    s2_d      = s1_q;
    s3_d      = s2_q;
    step_en_d = run_mode | (s2_q & ~s3_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wrn_q     <= 1'b1;
      data_q    <= '0;
      cnt_q     <= '0;
      ws_q      <= 4'(DEF_WAIT);
      ack_n_q   <= 1'b1;
      di_q      <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      step_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wrn_q     <= wrn_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      ws_q      <= ws_d;
      ack_n_q   <= ack_n_d;
      di_q      <= di_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      step_en_q <= step_en_d;
    end
  end

  // Contents survive reset; a reset at the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[addr_q[ADDR_WIDTH-1:0]] <= data_q;
  end

  assign ACK_N     = ack_n_q;
  assign DI        = di_q;
  assign step_en   = step_en_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_io_sim_mem.sv
// Directed bench for io_sim_mem: bus latency, decode errors, aborts, step pulses,
// counter saturation and mid-transaction reset.
module tb_io_sim_mem;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int OW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          AS_N, WR_N;
  logic [OW-1:0] AO;
  logic [DW-1:0] DO;
  logic          ACK_N;
  logic [DW-1:0] DI;
  logic [3:0]    ws_cfg;
  logic          ws_load, run_mode, step_in, step_en;
  logic [CW-1:0] rd_cnt, wr_cnt, err_cnt;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  io_sim_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AO_WIDTH(OW), .DEF_WAIT(0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .AS_N(AS_N), .WR_N(WR_N), .AO(AO), .DO(DO),
    .ACK_N(ACK_N), .DI(DI), .ws_cfg(ws_cfg), .ws_load(ws_load), .run_mode(run_mode),
    .step_in(step_in), .step_en(step_en), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: one full bus transaction; lat = edges after the sampling edge until ACK_N low
  task automatic txn(input string tag, input bit wr, input logic [OW-1:0] addr,
                     input logic [DW-1:0] data, input int hold, input int mid_load,
                     input int exp_lat);
    int lat;
    int extra;
    AS_N = 1'b0; WR_N = ~wr; AO = addr; DO = data;
    tick();
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      ws_load = 1'b0;
      if (ACK_N == 1'b0) begin
        lat = n;
        break;
      end
      if (n == mid_load) ws_load = 1'b1;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    extra = 0;
    for (int n = 0; n <= hold; n++) begin
      tick();
      if (ACK_N == 1'b0) extra++;
    end
    check({tag, "_single_ack"}, 64'(extra), 64'd0);
    AS_N = 1'b1;
    tick();
    tick();
  endtask

  task automatic load_ws(input logic [3:0] w);
    ws_cfg = w; ws_load = 1'b1;
    tick();
    ws_load = 1'b0;
  endtask

  task automatic step_burst(input string tag);
    int pulses;
    int first;
    pulses = 0; first = -1;
    step_in = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 20) step_in = 1'b0;
      if (step_en) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_delay"}, 64'(first), 64'd3);
  endtask

  initial begin
    int cnt;
    reset = 1'b0; AS_N = 1'b1; WR_N = 1'b1; AO = '0; DO = '0;
    ws_cfg = '0; ws_load = 1'b0; run_mode = 1'b0; step_in = 1'b0;
    repeat (3) tick();
    check("rst_ack_n", 64'(ACK_N), 64'd1);
    check("rst_di", 64'(DI), 64'd0);
    check("rst_step_en", 64'(step_en), 64'd0);
    check("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    check("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;
    tick();

    // W=0 write/read
    txn("wr0", 1'b1, 32'h0, 32'h0000_0A0A, 0, -1, 1);
    txn("wr5", 1'b1, 32'h5, 32'hDEAD_BEEF, 0, -1, 1);
    check("wr5_wr_cnt", 64'(wr_cnt), 64'd2);
    txn("rd5", 1'b0, 32'h5, 32'h0, 0, -1, 1);
    check("rd5_di", 64'(DI), 64'hDEAD_BEEF);
    check("rd5_rd_cnt", 64'(rd_cnt), 64'd1);

    // W=3, strobe held low afterwards
    load_ws(4'd3);
    txn("rd5_w3", 1'b0, 32'h5, 32'h0, 10, -1, 4);
    check("rd5_w3_di", 64'(DI), 64'hDEAD_BEEF);
    check("rd5_w3_rd_cnt", 64'(rd_cnt), 64'd2);

    // out of range
    txn("wr_oor", 1'b1, 32'h400, 32'h1234_5678, 0, -1, 4);
    check("wr_oor_err", 64'(err_cnt), 64'd1);
    check("wr_oor_wr_cnt", 64'(wr_cnt), 64'd2);
    check("wr_oor_di", 64'(DI), 64'hDEAD_BEEF);
    txn("rd_oor", 1'b0, 32'h400, 32'h0, 0, -1, 4);
    check("rd_oor_di", 64'(DI), 64'd0);
    check("rd_oor_err", 64'(err_cnt), 64'd2);
    check("rd_oor_rd_cnt", 64'(rd_cnt), 64'd2);
    txn("rd0", 1'b0, 32'h0, 32'h0, 0, -1, 4);
    check("rd0_di", 64'(DI), 64'h0000_0A0A);
    check("rd0_rd_cnt", 64'(rd_cnt), 64'd3);

    // abort with W=5
    load_ws(4'd5);
    AS_N = 1'b0; WR_N = 1'b0; AO = 32'h5; DO = 32'h1111_1111;
    tick();
    tick();
    tick();
    AS_N = 1'b1;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (ACK_N == 1'b0) cnt++;
    end
    check("abort_no_ack", 64'(cnt), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    check("abort_wr_cnt", 64'(wr_cnt), 64'd2);
    check("abort_rd_cnt", 64'(rd_cnt), 64'd3);
    check("abort_err_cnt", 64'(err_cnt), 64'd2);

    // load during WAIT leaves the in-flight wait alone
    ws_cfg = 4'd0;
    txn("rd5_midload", 1'b0, 32'h5, 32'h0, 0, 1, 6);
    check("rd5_midload_di", 64'(DI), 64'hDEAD_BEEF);
    txn("rd5_w0", 1'b0, 32'h5, 32'h0, 0, -1, 1);
    check("rd5_w0_rd_cnt", 64'(rd_cnt), 64'd5);

    // step logic
    step_burst("step1");
    step_burst("step2");
    step_burst("step3");
    run_mode = 1'b1;
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (step_en) cnt++;
    end
    check("run_mode_high", 64'(cnt), 64'd5);
    run_mode = 1'b0;
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (step_en) cnt++;
    end
    check("run_to_step_no_pulse", 64'(cnt), 64'd0);

    // counter saturation at 2^CW-1
    for (int i = 0; i < 4; i++) txn("rd_sat", 1'b0, 32'h5, 32'h0, 0, -1, 1);
    check("rd_cnt_sat", 64'(rd_cnt), 64'd7);

    // reset during WAIT of a W=4 write
    load_ws(4'd4);
    AS_N = 1'b0; WR_N = 1'b0; AO = 32'h5; DO = 32'h5555_5555;
    tick();
    tick();
    reset = 1'b0; AS_N = 1'b1;
    tick();
    check("midrst_ack_n", 64'(ACK_N), 64'd1);
    check("midrst_rd_cnt", 64'(rd_cnt), 64'd0);
    check("midrst_wr_cnt", 64'(wr_cnt), 64'd0);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    txn("post_rst_rd5", 1'b0, 32'h5, 32'h0, 0, -1, 1);
    check("post_rst_di", 64'(DI), 64'hDEAD_BEEF);
    check("post_rst_rd_cnt", 64'(rd_cnt), 64'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_sim_mem.md
Name: io_sim_mem

Overview:
- Parametrised bus-slave memory model with a clock/step front end for the DLX dual-core bus: answers AS_N/WR_N/AO/DO transactions with ACK_N and read data.
- Successor to the fixed-width IO simulator. Adds configurable data/address width, runtime-programmable wait states, abort handling, out-of-range error responses, run/step modes and access counters.
- Sits between the board/testbench and Dual_Core_Top, acting as main memory and single-step controller.

Parameters:
DATA_WIDTH, 32, bus data width (DO, DI, memory word)
ADDR_WIDTH, 10, memory depth is 2^ADDR_WIDTH words, word-addressed
AO_WIDTH, 32, width of the incoming address bus
DEF_WAIT, 0, wait-state count loaded at reset (0..15)
CNT_WIDTH, 16, width of the saturating access counters

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
AS_N  input  1  address strobe from master, active low
WR_N  input  1  0 = write, 1 = read; sampled with AS_N
AO  input  AO_WIDTH  address from master
DO  input  DATA_WIDTH  write data from master
ACK_N  output  1  transfer acknowledge, active low, one-cycle pulse
DI  output  DATA_WIDTH  read data to master
ws_cfg  input  4  new wait-state count
ws_load  input  1  load ws_cfg into wait register
run_mode  input  1  1 = free run, 0 = single step
step_in  input  1  raw step button/strobe (asynchronous)
step_en  output  1  step enable to core
rd_cnt  output  CNT_WIDTH  completed reads, saturating
wr_cnt  output  CNT_WIDTH  completed writes, saturating
err_cnt  output  CNT_WIDTH  out-of-range accesses, saturating

Behaviour:
- Reset (reset==0 at a clk edge):
  - ACK_N=1, DI=0, step_en=0, all counters 0.
  - Wait register = DEF_WAIT; FSM = IDLE; synchronizer flops = 0.
  - Memory contents are not cleared.
  - Reset mid-transaction aborts it: no write, no ACK.
- FSM states:
  - IDLE: on AS_N==0, latch AO, WR_N, DO; load wait counter = wait register; go to WAIT.
  - WAIT: if AS_N==1, abort and go to IDLE (no ACK, no write, no count). Else if counter==0, go to ACK. Else decrement.
  - ACK: ACK_N=0 for exactly this one cycle. Write is committed, or DI loaded, at the edge entering ACK. Go to RELEASE.
  - RELEASE: hold ACK_N=1 until AS_N==1, then go to IDLE. A strobe held low never produces a second ACK.
- Latency: AS_N sampled low at edge t gives ACK_N low during cycle t+1+W (W = wait value latched at t). W=0 gives a 1-cycle ACK.
- Address decode:
  - In range when AO[AO_WIDTH-1:ADDR_WIDTH]==0. Index = AO[ADDR_WIDTH-1:0].
  - Out of range: ACK is still given, a read returns DI=0, a write is dropped, err_cnt increments. rd_cnt/wr_cnt do not increment.
- DI is registered and holds its last read value until the next completed read; writes do not change DI.
- Wait register:
  - ws_load==1 updates it at the edge, in any state.
  - A load during WAIT does not affect the transaction in flight.
- Counters:
  - Increment at the edge entering ACK.
  - Saturate at 2^CNT_WIDTH-1 (no wrap).
- Step logic:
  - step_in passes through a 2-flop synchronizer, then a rising-edge detector.
  - run_mode==1: step_en=1 continuously.
  - run_mode==0: step_en is a one-cycle pulse, 3 cycles after the step_in rise. One pulse per rising edge; holding step_in high gives no repeats.
  - A change of run_mode takes effect on the next cycle; no spurious pulse on a 1->0 switch.
- Read and write to the same address in consecutive transactions: the read returns the newly written data.

Test Plan:
- W=0, write 0xDEADBEEF to AO=5, then read AO=5 -> ACK_N low 1 cycle after each strobe edge; DI=0xDEADBEEF; wr_cnt=1, rd_cnt=1.
- ws_cfg=3 with ws_load pulse, then read AO=5 -> ACK_N low exactly 4 cycles after AS_N sampled low, single-cycle pulse; AS_N held low 10 cycles gives no second ACK.
- Write 0x12345678 to AO=0x400 (ADDR_WIDTH=10) -> ACK given, err_cnt=1, wr_cnt unchanged. Then read AO=0x400 -> DI=0, err_cnt=2. Then read AO=0 -> not 0x12345678.
- W=5, AS_N raised 2 cycles after assertion -> no ACK, no write (memory word unchanged), counters unchanged, FSM back in IDLE, next transaction serviced normally.
- run_mode=0, step_in high for 20 cycles then low, repeated 3 times -> exactly 3 single-cycle step_en pulses, each 3 cycles after the rise. Switch to run_mode=1 -> step_en stays 1.
- reset driven low during WAIT of a write with W=4 -> ACK_N=1, counters 0, target word unchanged, wait register back to DEF_WAIT.
